uart_rx_deserializer: RTL and testbench

//  UART receive front end: samples serial rx at 16x oversampling and deserializes 5-8 data bits,

---
 rtl/serial_pkg.sv | 59 +++++
 rtl/baud_tick_gen.sv | 37 +++
 rtl/uart_rx_deserializer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial definitions: parity/receiver state encodings, oversampling
// constants and small helpers used by the UART receive path.
package serial_pkg;

  // Ticks per bit period; the vote points below assume exactly 16.
  localparam int OVERSAMPLE = 16;

  // Oversample tick indices (within a bit period) used for the majority vote.
  localparam logic [3:0] VOTE_TICKS [3] = '{4'd7, 4'd8, 4'd9};

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    EVEN  = 3'd1,
    ODD   = 3'd2,
    MARK  = 3'd3,
    SPACE = 3'd4
  } parity_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Map the raw parity_mode field onto the enum; reserved codes mean no parity.
  function automatic parity_t decode_parity(input logic [2:0] mode);
    parity_t p;
    case (mode)
      3'b001:  p = EVEN;
      3'b010:  p = ODD;
      3'b011:  p = MARK;
      3'b100:  p = SPACE;
      default: p = NONE;
    endcase
    return p;
  endfunction

  // Two-out-of-three majority.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent, given XOR of the data bits.
  function automatic logic expected_parity(input parity_t mode, input logic data_xor);
    logic e;
    case (mode)
      EVEN:    e = data_xor;
      ODD:     e = ~data_xor;
      MARK:    e = 1'b1;
      SPACE:   e = 1'b0;
      default: e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clock tick every 'divisor' clocks (0 acts as 1).
// The divisor is latched on restart, which also realigns the tick phase.
module baud_tick_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] divisor,
  input  logic        restart,
  input  logic        run,
  output logic        tick
);

  logic [15:0] reload_s;
  logic [15:0] reload_r;
  logic [15:0] count_r;

  assign reload_s = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);

  // Down-counter: load on restart, free-run and reload at zero while running.
  always_ff @(posedge clock) begin
    if (reset) begin
      reload_r <= 16'd0;
      count_r  <= 16'd0;
    end else if (restart) begin
      reload_r <= reload_s;
      count_r  <= reload_s;
    end else if (run) begin
      if (count_r == 16'd0) begin
        count_r <= reload_r;
      end else begin
        count_r <= count_r - 16'd1;
      end
    end
  end

  assign tick = run && (count_r == 16'd0);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 16x oversampled, majority-voted deserializer for
// 5-8 data bits, optional parity and 1/2 stop bits, feeding the RX FIFO.
// Optional feature macro: BREAK_DETECT_EN (adds sticky break_detected output;
// a break frame is then swallowed instead of written with a framing error).
module uart_rx_deserializer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx,
  input  logic [15:0] baud_divisor,
  input  logic [1:0]  data_bits,
  input  logic [2:0]  parity_mode,
  input  logic        two_stop,
  input  logic        clear_errors,
  output logic        wr_request,
  output logic [8:0]  wr_data,
`ifdef BREAK_DETECT_EN
  output logic        break_detected,
`endif
  output logic        busy,
  output logic        parity_error,
  output logic        framing_error
);

  import serial_pkg::*;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  rx_state_t             state_r, state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                  rx_s;
  logic                  tick_s;
  logic                  run_s;
  logic                  start_det_s;
  logic                  vote_now_s;
  logic                  vote_s;

  logic [3:0]            sample_cnt_r;
  logic                  samp0_r, samp1_r;
  logic [2:0]            bit_cnt_r;
  logic                  stop_cnt_r;
  logic [7:0]            shreg_r;
  logic                  par_acc_r;
  logic                  perr_acc_r;
  logic                  ferr_acc_r;

  logic [1:0]            data_bits_r;
  parity_t               parity_r;
  logic                  two_stop_r;

  logic                  last_data_s;
  logic                  last_stop_s;
  logic                  frame_bad_s;
  logic                  write_s;
  logic                  perr_set_s;
  logic                  ferr_set_s;

  logic                  wr_request_r;
  logic [8:0]            wr_data_r;
  logic                  busy_r;
  logic                  parity_error_r;
  logic                  framing_error_r;

`ifdef BREAK_DETECT_EN
  logic                  seen_one_r;
  logic                  brk_set_s;
  logic                  break_detected_r;
`endif

  // Metastability chain for the asynchronous rx line (resets to idle-high).
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s        = sync_r[SYNC_STAGES-1];
  assign run_s       = (state_r == START) || (state_r == DATA) ||
                       (state_r == PARITY) || (state_r == STOP);
  assign start_det_s = (state_r == IDLE) && enable && !rx_s;
  assign vote_now_s  = tick_s && (sample_cnt_r == VOTE_TICKS[2]);
  assign vote_s      = majority3(samp0_r, samp1_r, rx_s);
  assign last_data_s = (bit_cnt_r == (3'd4 + {1'b0, data_bits_r}));
  assign last_stop_s = !two_stop_r || stop_cnt_r;
  assign frame_bad_s = ferr_acc_r | ~vote_s;

  baud_tick_gen u_tick (
    .clock   (clock),
    .reset   (reset),
    .divisor (baud_divisor),
    .restart (start_det_s),
    .run     (run_s),
    .tick    (tick_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-character event decode; one vote consumed per bit.
  always_comb begin
    state_s    = state_r;
    write_s    = 1'b0;
    perr_set_s = 1'b0;
    ferr_set_s = 1'b0;
`ifdef BREAK_DETECT_EN
    brk_set_s  = 1'b0;
`endif
    if (!enable && (state_r != IDLE)) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_det_s) begin
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (vote_now_s) begin
            state_s = vote_s ? IDLE : DATA;
          end else begin
            state_s = START;
          end
        end
        DATA: begin
          if (vote_now_s && last_data_s) begin
            state_s = (parity_r != NONE) ? PARITY : STOP;
          end else begin
            state_s = DATA;
          end
        end
        PARITY: begin
          if (vote_now_s) begin
            state_s = STOP;
          end else begin
            state_s = PARITY;
          end
        end
        STOP: begin
          if (!vote_now_s) begin
            state_s = STOP;
`ifdef BREAK_DETECT_EN
          end else if (!stop_cnt_r && !vote_s && !seen_one_r) begin
            brk_set_s = 1'b1;
            state_s   = WAIT_HIGH;
`endif
          end else if (last_stop_s) begin
            write_s    = 1'b1;
            perr_set_s = perr_acc_r;
            ferr_set_s = frame_bad_s;
            state_s    = vote_s ? IDLE : WAIT_HIGH;
          end else begin
            state_s = STOP;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_s = IDLE;
          end else begin
            state_s = WAIT_HIGH;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Frame datapath: config capture, oversample position, vote samples, shifting.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_bits_r  <= 2'd0;
      parity_r     <= NONE;
      two_stop_r   <= 1'b0;
      sample_cnt_r <= 4'd0;
      samp0_r      <= 1'b1;
      samp1_r      <= 1'b1;
      bit_cnt_r    <= 3'd0;
      stop_cnt_r   <= 1'b0;
      shreg_r      <= 8'h00;
      par_acc_r    <= 1'b0;
      perr_acc_r   <= 1'b0;
      ferr_acc_r   <= 1'b0;
    end else if (start_det_s) begin
      data_bits_r  <= data_bits;
      parity_r     <= decode_parity(parity_mode);
      two_stop_r   <= two_stop;
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= 3'd0;
      stop_cnt_r   <= 1'b0;
      shreg_r      <= 8'h00;
      par_acc_r    <= 1'b0;
      perr_acc_r   <= 1'b0;
      ferr_acc_r   <= 1'b0;
    end else if (tick_s) begin
      sample_cnt_r <= (sample_cnt_r == LAST_TICK) ? 4'd0 : (sample_cnt_r + 4'd1);
      if (sample_cnt_r == VOTE_TICKS[0]) begin
        samp0_r <= rx_s;
      end
      if (sample_cnt_r == VOTE_TICKS[1]) begin
        samp1_r <= rx_s;
      end
      if (vote_now_s) begin
        case (state_r)
          DATA: begin
            shreg_r[bit_cnt_r] <= vote_s;
            par_acc_r          <= par_acc_r ^ vote_s;
            bit_cnt_r          <= bit_cnt_r + 3'd1;
          end
          PARITY: begin
            perr_acc_r <= (vote_s != expected_parity(parity_r, par_acc_r));
          end
          STOP: begin
            stop_cnt_r <= 1'b1;
            ferr_acc_r <= ferr_acc_r | ~vote_s;
          end
          default: begin
            stop_cnt_r <= stop_cnt_r;
          end
        endcase
      end
    end
  end

`ifdef BREAK_DETECT_EN
  // Remember whether any data or parity bit of this frame voted high.
  always_ff @(posedge clock) begin
    if (reset) begin
      seen_one_r <= 1'b0;
    end else if (start_det_s) begin
      seen_one_r <= 1'b0;
    end else if (vote_now_s && vote_s && ((state_r == DATA) || (state_r == PARITY))) begin
      seen_one_r <= 1'b1;
    end
  end

  // Sticky break flag; a new break beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      break_detected_r <= 1'b0;
    end else if (brk_set_s) begin
      break_detected_r <= 1'b1;
    end else if (clear_errors) begin
      break_detected_r <= 1'b0;
    end
  end

  assign break_detected = break_detected_r;
`endif

  // FIFO write port: single-cycle pulse, data held until the next character.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_request_r <= 1'b0;
      wr_data_r    <= 9'h000;
    end else begin
      wr_request_r <= write_s;
      if (write_s) begin
        wr_data_r <= {perr_acc_r | frame_bad_s, shreg_r};
      end
    end
  end

  // Busy covers everything from start detection until back in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_error_r  <= 1'b0;
      framing_error_r <= 1'b0;
    end else begin
      if (perr_set_s) begin
        parity_error_r <= 1'b1;
      end else if (clear_errors) begin
        parity_error_r <= 1'b0;
      end
      if (ferr_set_s) begin
        framing_error_r <= 1'b1;
      end else if (clear_errors) begin
        framing_error_r <= 1'b0;
      end
    end
  end

  assign wr_request    = wr_request_r;
  assign wr_data       = wr_data_r;
  assign busy          = busy_r;
  assign parity_error  = parity_error_r;
  assign framing_error = framing_error_r;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed self-checking bench for uart_rx_deserializer (100 MHz clock).
module tb_uart_rx_deserializer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] baud_divisor = 16'd54;
  logic [1:0]  data_bits = 2'b11;
  logic [2:0]  parity_mode = 3'b000;
  logic        two_stop = 1'b0;
  logic        clear_errors = 1'b0;
  logic        wr_request;
  logic [8:0]  wr_data;
  logic        busy;
  logic        parity_error;
  logic        framing_error;
`ifdef BREAK_DETECT_EN
  logic        break_detected;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc = 0;
  logic [8:0] last_data = 9'h000;

  uart_rx_deserializer #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .rx            (rx),
    .baud_divisor  (baud_divisor),
    .data_bits     (data_bits),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .clear_errors  (clear_errors),
    .wr_request    (wr_request),
    .wr_data       (wr_data),
`ifdef BREAK_DETECT_EN
    .break_detected(break_detected),
`endif
    .busy          (busy),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  always #5 clock = ~clock;

  // Cycle counter for latency measurement.
  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (wr_request) begin
      wr_cnt    = wr_cnt + 1;
      last_data = wr_data;
      wr_cyc    = cyc;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive n serial bits LSB-first, each lasting 16*div clocks; called at a negedge.
  task automatic send_bits(input logic [15:0] bits, input int n, input int div);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (16 * div) @(negedge clock);
    end
  endtask

  task automatic idle_bits(input int n, input int div);
    rx = 1'b1;
    repeat (16 * div * n) @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int base_cnt;
    int start_cyc;
    int lat;

    repeat (4) @(negedge clock);
    check_value("rst_wr_request", 32'(wr_request), 32'd0);
    check_value("rst_wr_data", 32'(wr_data), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_parity_error", 32'(parity_error), 32'd0);
    check_value("rst_framing_error", 32'(framing_error), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clock);

    // 8N1 at divisor 54: 0x55.
    base_cnt  = wr_cnt;
    start_cyc = cyc;
    send_bits({1'b1, 8'h55, 1'b0}, 10, 54);
    idle_bits(1, 54);
    lat = wr_cyc - start_cyc;
    check_value("8n1_write_count", 32'(wr_cnt - base_cnt), 32'd1);
    check_value("8n1_wr_data", 32'(last_data), 32'h055);
    check_value("8n1_latency_window", 32'((lat >= 8317) && (lat <= 8321)), 32'd1);
    check_value("8n1_no_ferr", 32'(framing_error), 32'd0);
    check_value("8n1_busy_idle", 32'(busy), 32'd0);

    // 8E1 at divisor 4: 0xA3 with wrong parity bit 1.
    baud_divisor = 16'd4;
    parity_mode  = 3'b001;
    base_cnt     = wr_cnt;
    send_bits({1'b1, 1'b1, 8'hA3, 1'b0}, 11, 4);
    idle_bits(1, 4);
    check_value("8e1_write_count", 32'(wr_cnt - base_cnt), 32'd1);
    check_value("8e1_wr_data", 32'(last_data), 32'h1A3);
    check_value("8e1_parity_error", 32'(parity_error), 32'd1);
    check_value("8e1_no_ferr", 32'(framing_error), 32'd0);
    pulse_clear();
    check_value("8e1_perr_cleared", 32'(parity_error), 32'd0);

    // 8N1: 0x3C with stop bit held low, line stays low afterwards.
    parity_mode = 3'b000;
    base_cnt    = wr_cnt;
    send_bits({1'b0, 8'h3C, 1'b0}, 10, 4);
    repeat (128) @(negedge clock);
    check_value("stop0_wr_data", 32'(last_data), 32'h13C);
    check_value("stop0_framing_error", 32'(framing_error), 32'd1);
    check_value("stop0_busy_wait_high", 32'(busy), 32'd1);
    check_value("stop0_write_count", 32'(wr_cnt - base_cnt), 32'd1);
    rx = 1'b1;
    repeat (8) @(negedge clock);
    check_value("stop0_idle_after_high", 32'(busy), 32'd0);
    pulse_clear();
    check_value("stop0_ferr_cleared", 32'(framing_error), 32'd0);

    // Glitch: rx low for only 4 ticks (16 clocks at divisor 4).
    base_cnt = wr_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clock);
    idle_bits(2, 4);
    check_value("glitch_no_write", 32'(wr_cnt - base_cnt), 32'd0);
    check_value("glitch_busy_low", 32'(busy), 32'd0);
    check_value("glitch_no_perr", 32'(parity_error), 32'd0);
    check_value("glitch_no_ferr", 32'(framing_error), 32'd0);

    // 5O2: 0x1F (five ones -> odd parity bit 0), two stop bits.
    data_bits   = 2'b00;
    parity_mode = 3'b010;
    two_stop    = 1'b1;
    base_cnt    = wr_cnt;
    send_bits({2'b11, 1'b0, 5'h1F, 1'b0}, 9, 4);
    idle_bits(1, 4);
    check_value("5o2_write_count", 32'(wr_cnt - base_cnt), 32'd1);
    check_value("5o2_wr_data", 32'(last_data), 32'h01F);
    check_value("5o2_no_perr", 32'(parity_error), 32'd0);

    // Reset mid-frame: start plus three data bits, then reset.
    base_cnt = wr_cnt;
    send_bits(16'h000E, 4, 4);
    check_value("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_value("midrst_wr_data", 32'(wr_data), 32'd0);
    check_value("midrst_busy", 32'(busy), 32'd0);
    check_value("midrst_wr_request", 32'(wr_request), 32'd0);
    rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle_bits(2, 4);
    check_value("midrst_no_write", 32'(wr_cnt - base_cnt), 32'd0);
    check_value("midrst_idle", 32'(busy), 32'd0);

    // Break: rx low for 12 bit times, 8N1.
    data_bits   = 2'b11;
    parity_mode = 3'b000;
    two_stop    = 1'b0;
    base_cnt    = wr_cnt;
    send_bits(16'h0000, 12, 4);
    idle_bits(1, 4);
`ifdef BREAK_DETECT_EN
    check_value("break_detected", 32'(break_detected), 32'd1);
    check_value("break_no_write", 32'(wr_cnt - base_cnt), 32'd0);
    check_value("break_no_ferr", 32'(framing_error), 32'd0);
    pulse_clear();
    check_value("break_cleared", 32'(break_detected), 32'd0);
`else
    check_value("break_write_count", 32'(wr_cnt - base_cnt), 32'd1);
    check_value("break_wr_data", 32'(last_data), 32'h100);
    check_value("break_framing_error", 32'(framing_error), 32'd1);
`endif
    check_value("break_busy_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
